// File: rtl/vend_credit_ctrl_pkg.sv
// Purpose : shared constants for the vending credit controller (state codes, tokens, bill values, prices).
// Latency : n/a (package only).
// Backpr. : n/a (package only).
package vend_credit_ctrl_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_COLLECT  = 3'd1;
  localparam logic [2:0] ST_VEND     = 3'd2;
  localparam logic [2:0] ST_CHANGE   = 3'd3;
  localparam logic [2:0] ST_WAIT_ACK = 3'd4;

  // change token codes on V
  localparam logic [2:0] TOK_NONE = 3'b000;
  localparam logic [2:0] TOK_TWO  = 3'b010;
  localparam logic [2:0] TOK_ONE  = 3'b001;

  // bill face values
  localparam logic [3:0] BILL1_VAL = 4'd1;
  localparam logic [3:0] BILL2_VAL = 4'd2;
  localparam logic [3:0] BILL5_VAL = 4'd5;

  // default product prices (must stay within 1..7)
  localparam int DEF_PRICE0 = 2;
  localparam int DEF_PRICE1 = 3;
  localparam int DEF_PRICE2 = 4;
  localparam int DEF_PRICE3 = 5;

  function automatic logic is_onehot4(input logic [3:0] p);
    return (p == 4'b0001) || (p == 4'b0010) || (p == 4'b0100) || (p == 4'b1000);
  endfunction

  // edges[0] = 1-unit bill, edges[1] = 2-unit bill, edges[2] = 5-unit bill
  function automatic logic [3:0] bill_sum(input logic [2:0] edges);
    logic [3:0] s;
    s = 4'd0;
    if (edges[0]) s = s + BILL1_VAL;
    if (edges[1]) s = s + BILL2_VAL;
    if (edges[2]) s = s + BILL5_VAL;
    return s;
  endfunction

endpackage

// File: rtl/vend_credit_ctrl_bill_edge.sv
// Purpose : 3-bit rising-edge detector for the bill-present levels.
// Latency : edge flagged combinationally in the cycle the level first reads high; history registered.
// Backpr. : none; a level held high yields exactly one edge.
// Ports   : clock, reset (sync, active-high), bills[2:0] levels in, edges[2:0] one-cycle pulses out.
module bill_edge (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] bills,
  output logic [2:0] edges
);

  logic [2:0] bills_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      bills_q <= 3'b000;
    end else begin
      bills_q <= bills;
    end
  end

  assign edges = bills & ~bills_q;

endmodule

// File: rtl/vend_credit_ctrl.sv
// Purpose : payment/credit controller: latch product, accumulate bills, pulse EN, pay change as V tokens.
// Latency : P valid n -> PF at n+1; bill edge at n -> credit n+1, EN n+2; V one cycle after entering CHANGE.
// Backpr. : each change token waits for chg_done from the change FSM before the next is issued.
// Ports   : clock, reset, P[3:0], B1/B2/B5, [cancel], chg_done in; EN, PF[3:0], V[2:0], credit[3:0], busy out.
// Config  : VEND_CANCEL_EN adds the cancel input (refund of accumulated credit from COLLECT).
module vend_credit_ctrl
  import vend_credit_ctrl_pkg::*;
#(
  parameter int PRICE0 = DEF_PRICE0,
  parameter int PRICE1 = DEF_PRICE1,
  parameter int PRICE2 = DEF_PRICE2,
  parameter int PRICE3 = DEF_PRICE3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] P,
  input  logic       B1,
  input  logic       B2,
  input  logic       B5,
`ifdef VEND_CANCEL_EN
  input  logic       cancel,
`endif
  input  logic       chg_done,
  output logic       EN,
  output logic [3:0] PF,
  output logic [2:0] V,
  output logic [3:0] credit,
  output logic       busy
);

  localparam logic [3:0] PRICE0_V = PRICE0[3:0];
  localparam logic [3:0] PRICE1_V = PRICE1[3:0];
  localparam logic [3:0] PRICE2_V = PRICE2[3:0];
  localparam logic [3:0] PRICE3_V = PRICE3[3:0];

  logic [2:0] state;
  logic [3:0] price;       // price of the latched product
  logic [3:0] rem;         // change still owed
  logic [2:0] bill_edges;
  logic [3:0] credit_next;
  logic [3:0] price_sel;
  logic [2:0] tok;
  logic [3:0] tok_val;
  logic       cancel_req;

`ifdef VEND_CANCEL_EN
  assign cancel_req = cancel;
`else
  assign cancel_req = 1'b0;
`endif

  bill_edge u_bill_edge (
    .clock (clock),
    .reset (reset),
    .bills ({B5, B2, B1}),
    .edges (bill_edges)
  );

  // Credit stays below the price (<= 6) before an add and an add is at most 8,
  // so the 4-bit sum cannot wrap even on the cancel path.
  assign credit_next = credit + bill_sum(bill_edges);

  always_comb begin
    price_sel = 4'd0;
    case (P)
      4'b0001: price_sel = PRICE0_V;
      4'b0010: price_sel = PRICE1_V;
      4'b0100: price_sel = PRICE2_V;
      4'b1000: price_sel = PRICE3_V;
      default: price_sel = 4'd0;
    endcase
  end

  // Token choice depends only on rem, which is stable between CHANGE and
  // WAIT_ACK, so the same value is both issued and later subtracted.
  always_comb begin
    if (rem >= 4'd2) begin
      tok     = TOK_TWO;
      tok_val = 4'd2;
    end else begin
      tok     = TOK_ONE;
      tok_val = 4'd1;
    end
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      credit <= 4'd0;
      PF     <= 4'd0;
      price  <= 4'd0;
      rem    <= 4'd0;
      EN     <= 1'b0;
      V      <= TOK_NONE;
    end else begin
      // EN and V are registered off the state, so each appears one cycle
      // after its state and lasts exactly one cycle.
      EN <= (state == ST_VEND);
      V  <= (state == ST_CHANGE) ? tok : TOK_NONE;

      case (state)
        ST_IDLE: begin
          credit <= 4'd0;
          if (is_onehot4(P)) begin
            PF    <= P;
            price <= price_sel;
            state <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (cancel_req) begin
            // a bill arriving in the cancel cycle is part of the refund
            rem    <= credit_next;
            credit <= 4'd0;
            PF     <= 4'd0;
            state  <= (credit_next == 4'd0) ? ST_IDLE : ST_CHANGE;
          end else begin
            credit <= credit_next;
            if (credit_next >= price) begin
              state <= ST_VEND;
            end
          end
        end

        ST_VEND: begin
          rem    <= credit - price;
          credit <= 4'd0;
          PF     <= 4'd0;
          state  <= (credit == price) ? ST_IDLE : ST_CHANGE;
        end

        ST_CHANGE: begin
          state <= ST_WAIT_ACK;
        end

        ST_WAIT_ACK: begin
          if (chg_done) begin
            rem   <= rem - tok_val;
            state <= (rem == tok_val) ? ST_IDLE : ST_CHANGE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Purpose : self-checking bench for vend_credit_ctrl with an output-event scoreboard.
// Latency : n/a (testbench).
// Backpr. : chg_done answered automatically two cycles after each V token unless disabled.
module tb_vend_credit_ctrl;

  localparam logic [7:0] EVT_EN  = 8'h10;
  localparam logic [7:0] EVT_TWO = 8'h02;
  localparam logic [7:0] EVT_ONE = 8'h01;

  logic       clock;
  logic       reset;
  logic [3:0] P;
  logic       B1, B2, B5;
  logic       cancel;
  logic       chg_done;
  logic       EN;
  logic [3:0] PF;
  logic [2:0] V;
  logic [3:0] credit;
  logic       busy;

  int         chk_cnt;
  int         err_cnt;
  bit         auto_ack;
  logic [7:0] exp_q[$];

  vend_credit_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .P        (P),
    .B1       (B1),
    .B2       (B2),
    .B5       (B5),
`ifdef VEND_CANCEL_EN
    .cancel   (cancel),
`endif
    .chg_done (chg_done),
    .EN       (EN),
    .PF       (PF),
    .V        (V),
    .credit   (credit),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic sb_compare(input logic [7:0] ev);
    if (exp_q.size() == 0) begin
      check_val("sb_unexpected", {24'd0, ev}, 32'hFF);
    end else begin
      check_val("sb_out", {24'd0, ev}, {24'd0, exp_q.pop_front()});
    end
  endtask

  // output monitor: every EN pulse and non-zero V token must match the queue head
  always @(negedge clock) begin
    if (!reset) begin
      if (EN) sb_compare(EVT_EN);
      if (V != 3'b000) sb_compare({5'd0, V});
    end
  end

  // change FSM model: finish each token two cycles after it appears
  initial begin
    chg_done = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset && auto_ack && V != 3'b000) begin
        repeat (2) @(posedge clock);
        #1 chg_done = 1'b1;
        @(posedge clock);
        #1 chg_done = 1'b0;
      end
    end
  end

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      cyc();
      n++;
    end
    check_val({tag, "_idle"}, {31'd0, busy}, 32'd0);
    repeat (3) cyc();
    check_val({tag, "_drain"}, exp_q.size(), 32'd0);
  endtask

  task automatic select(input logic [3:0] p);
    P = p;
    cyc();
    P = 4'b0000;
  endtask

  initial begin
    int n;
    chk_cnt  = 0;
    err_cnt  = 0;
    auto_ack = 1'b1;
    reset    = 1'b1;
    P        = 4'b0000;
    B1 = 1'b0; B2 = 1'b0; B5 = 1'b0;
    cancel   = 1'b0;
    repeat (3) cyc();
    check_val("rst_en", {31'd0, EN}, 32'd0);
    check_val("rst_v", {29'd0, V}, 32'd0);
    check_val("rst_pf", {28'd0, PF}, 32'd0);
    check_val("rst_credit", {28'd0, credit}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    cyc();

    // exact payment: price 3, B2 then B1
    select(4'b0010);
    check_val("t1_busy", {31'd0, busy}, 32'd1);
    check_val("t1_pf", {28'd0, PF}, 32'h2);
    check_val("t1_credit0", {28'd0, credit}, 32'd0);
    exp_q.push_back(EVT_EN);
    B2 = 1'b1; cyc(); B2 = 1'b0;
    check_val("t1_credit2", {28'd0, credit}, 32'd2);
    B1 = 1'b1; cyc(); B1 = 1'b0;
    check_val("t1_credit3", {28'd0, credit}, 32'd3);
    check_val("t1_en_lag", {31'd0, EN}, 32'd0);
    cyc();
    check_val("t1_en", {31'd0, EN}, 32'd1);
    wait_idle("t1");

    // overpay: price 2, B5 -> change 3 (two then one)
    select(4'b0001);
    exp_q.push_back(EVT_EN);
    exp_q.push_back(EVT_TWO);
    exp_q.push_back(EVT_ONE);
    B5 = 1'b1; cyc(); B5 = 1'b0;
    check_val("t2_credit", {28'd0, credit}, 32'd5);
    wait_idle("t2");
    check_val("t2_credit_end", {28'd0, credit}, 32'd0);

    // simultaneous bills: price 5, 1+2+5 = 8 -> change 3
    select(4'b1000);
    exp_q.push_back(EVT_EN);
    exp_q.push_back(EVT_TWO);
    exp_q.push_back(EVT_ONE);
    B1 = 1'b1; B2 = 1'b1; B5 = 1'b1; cyc();
    B1 = 1'b0; B2 = 1'b0; B5 = 1'b0;
    check_val("t3_credit", {28'd0, credit}, 32'd8);
    wait_idle("t3");

    // held bill counts once: price 4, B2 high 10 cycles
    select(4'b0100);
    B2 = 1'b1;
    repeat (10) cyc();
    B2 = 1'b0;
    cyc();
    check_val("t4_credit", {28'd0, credit}, 32'd2);
    check_val("t4_busy", {31'd0, busy}, 32'd1);
    check_val("t4_pf", {28'd0, PF}, 32'h4);
    reset = 1'b1; cyc(); reset = 1'b0;
    check_val("t4_rst_busy", {31'd0, busy}, 32'd0);
    check_val("t4_rst_credit", {28'd0, credit}, 32'd0);
    cyc();

    // invalid selections are ignored
    select(4'b0011);
    cyc();
    check_val("t5_multi_busy", {31'd0, busy}, 32'd0);
    check_val("t5_multi_pf", {28'd0, PF}, 32'd0);
    select(4'b0000);
    cyc();
    check_val("t5_zero_busy", {31'd0, busy}, 32'd0);

    // reset while waiting for chg_done
    auto_ack = 1'b0;
    select(4'b0001);
    exp_q.push_back(EVT_EN);
    exp_q.push_back(EVT_TWO);
    B5 = 1'b1; cyc(); B5 = 1'b0;
    n = 0;
    while (V == 3'b000 && n < 50) begin
      cyc();
      n++;
    end
    check_val("t6_token", {29'd0, V}, 32'h2);
    @(negedge clock);
    #1 reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_val("t6_en", {31'd0, EN}, 32'd0);
    check_val("t6_v", {29'd0, V}, 32'd0);
    check_val("t6_pf", {28'd0, PF}, 32'd0);
    check_val("t6_credit", {28'd0, credit}, 32'd0);
    check_val("t6_busy", {31'd0, busy}, 32'd0);
    repeat (3) cyc();
    check_val("t6_drain", exp_q.size(), 32'd0);
    auto_ack = 1'b1;

`ifdef VEND_CANCEL_EN
    // cancel refunds 3 with no EN
    select(4'b1000);
    exp_q.push_back(EVT_TWO);
    exp_q.push_back(EVT_ONE);
    B2 = 1'b1; cyc(); B2 = 1'b0;
    B1 = 1'b1; cyc(); B1 = 1'b0;
    check_val("t7_credit", {28'd0, credit}, 32'd3);
    cancel = 1'b1; cyc(); cancel = 1'b0;
    check_val("t7_pf", {28'd0, PF}, 32'd0);
    wait_idle("t7");
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vend_credit_ctrl.md
# vend_credit_ctrl

Payment and credit controller for the vending machine: latches a one-hot product selection, accumulates inserted bill value, issues a one-cycle vend enable once the product price is covered, then emits the change owed as a sequence of change tokens. It sits upstream of the product-distribution and change-duration FSMs. It drives their `EN` and `V[2:0]` inputs and waits on the change FSM's completion handshake.

## Interface
- `PRICE0`, default 2: price of product code 4'b0001
- `PRICE1`, default 3: price of product code 4'b0010
- `PRICE2`, default 4: price of product code 4'b0100
- `PRICE3`, default 5: price of product code 4'b1000
- `clock`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `P`  in  4  product select, one-hot, level
- `B1`, `B2`, `B5`  in  1 each  bill-present levels, values 1, 2, 5
- `cancel`  in  1  refund request, present only with `VEND_CANCEL_EN`
- `chg_done`  in  1  change FSM finished current token (its z2 timer)
- `EN`  out  1  vend pulse to distribution FSM
- `PF`  out  4  latched one-hot product, valid from COLLECT through VEND
- `V`  out  3  change token: 3'b010 = 2 units, 3'b001 = 1 unit, else 3'b000
- `credit`  out  4  current accumulated credit
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, COLLECT, VEND, CHANGE, WAIT_ACK.
- IDLE: credit = 0. `P` is accepted only when exactly one bit is set; all-zero and multi-hot values are ignored. On a valid `P`, latch `PF`, load the price, and go to COLLECT.
- Bill edges: each of `B1`/`B2`/`B5` is registered, and only a rising edge counts. A held level counts once.
- COLLECT: `credit += 1*e1 + 2*e2 + 5*e5`. Simultaneous edges are all summed in the same cycle. When the updated credit is ≥ price, go to VEND. `P` changes are ignored.
- VEND: `EN` = 1 for exactly one cycle. Set remaining change = credit − price (range 0..7). If the remainder is 0, go to IDLE; otherwise go to CHANGE.
- CHANGE: drive `V` = 3'b010 for one cycle if remaining ≥ 2, else `V` = 3'b001. Go to WAIT_ACK.
- WAIT_ACK: `V` = 0. On `chg_done` = 1, subtract the token value from remaining. If the result is 0, go to IDLE; otherwise go to CHANGE.
- Bill edges in VEND, CHANGE and WAIT_ACK are discarded. Edge registers still update, so a level held across the return to IDLE/COLLECT does not count again.
- Arithmetic: credit is 4-bit. Maximum is 4 + 8 = 12 (credit < 5 before an add), so no overflow with default prices. `PRICEn` must be in 1..7.

## Timing
- Reset: state IDLE, `credit` = 0, `PF` = 0, `EN` = 0, `V` = 0, `busy` = 0, edge registers = 0. Reset mid-transaction aborts it and credit is lost.
- `P` valid in cycle n → COLLECT and `PF` valid at n+1.
- Bill rising edge sampled at cycle n → `credit` updated at n+1. If price is reached, `EN` is high at n+2.
- `V` token is a one-cycle pulse in the cycle after entering CHANGE. The next token follows at least two cycles after `chg_done`.
- `chg_done` outside WAIT_ACK is ignored.

## Configuration
- `VEND_CANCEL_EN` defined: `cancel` port exists. `cancel` = 1 in COLLECT sets remaining = credit and clears `PF`. If credit is 0, go to IDLE; otherwise go to CHANGE, and `EN` is never asserted. `cancel` in other states is ignored. If a bill edge and `cancel` occur in the same cycle, that bill is included in the refund.
- Not defined: no `cancel` port; COLLECT exits only on price reached or reset.

## Structure
- Shared package: state encoding constants, token codes `TOK_TWO` = 3'b010 and `TOK_ONE` = 3'b001, bill values, default prices.
- One sub-module: `bill_edge`, a 3-bit rising-edge detector with synchronous reset, instantiated once.

## Test plan
- `P` = 4'b0010, one `B2` edge, then one `B1` edge → `credit` 2 then 3, `EN` pulse one cycle, `V` stays 0, back to IDLE.
- `P` = 4'b0001, one `B5` edge → `EN`, then `V` = 010, `chg_done`, `V` = 001, `chg_done` → IDLE (change 3).
- `P` = 4'b1000, `B1`, `B2` and `B5` rising in the same cycle → `credit` = 8, `EN`, then tokens 010 and 001.
- `B2` held high for 10 cycles with `P` = 4'b0100 → credited once only (`credit` = 2), no `EN`.
- `P` = 4'b0011 or 4'b0000 → stays IDLE, `busy` = 0. Reset asserted in WAIT_ACK → all outputs 0 on the next cycle.
- With `VEND_CANCEL_EN`: `P` = 4'b1000, `B2`, `B1`, then `cancel` → no `EN`, tokens 010 then 001, IDLE.
